// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA geometry constants, rectangle defaults and overlay types
package vga_pkg;

    localparam int HOR_PIXELS  = 800;
    localparam int VER_PIXELS  = 600;

    localparam int          W_OF_REC    = 400;
    localparam int          H_OF_REC    = 300;
    localparam logic [11:0] C_OF_REC    = 12'hAF0;
    localparam int          X_OF_REC    = 100;
    localparam int          Y_OF_REC    = 200;
    localparam int          RECT_STEP_X = 2;
    localparam int          RECT_STEP_Y = 1;

    typedef logic [10:0] pix_t;
    typedef logic [11:0] rgb_t;

    typedef enum logic [1:0] {
        WAIT_VBLNK = 2'd0,
        COUNT      = 2'd1,
        UPDATE     = 2'd2
    } rect_state_t;

    // FWD is right for x and down for y
    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_t;

    typedef struct packed {
        pix_t pos;
        dir_t dir;
    } axis_t;

    typedef struct packed {
        pix_t vcount;
        pix_t hcount;
        logic vsync;
        logic hsync;
        logic vblnk;
        logic hblnk;
        rgb_t rgb;
    } tbus_t;

    // One bounce step on a single axis; limit is the largest legal edge position.
    // 12-bit sums keep pos + step from wrapping.
    function automatic axis_t bounce(pix_t pos, dir_t dir, logic [11:0] step,
                                     logic [11:0] limit);
        axis_t       r;
        logic [11:0] p;
        p = {1'b0, pos};
        r = '{pos: pos, dir: dir};
        if (dir == DIR_FWD) begin
            if (p + step >= limit) begin
                r.pos = limit[10:0];
                r.dir = DIR_REV;
            end else begin
                r.pos = pos + step[10:0];
            end
        end else begin
            if (p <= step) begin
                r.pos = '0;
                r.dir = DIR_FWD;
            end else begin
                r.pos = pos - step[10:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/draw_rect_move_if.sv
// rtl/draw_rect_move_if.sv - VGA timing bus carried into and out of the overlay
interface draw_rect_move_if;
    import vga_pkg::*;

    pix_t vcount;
    pix_t hcount;
    logic vsync;
    logic hsync;
    logic vblnk;
    logic hblnk;
    rgb_t rgb;

    modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport slave  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);

endinterface

// File: rtl/draw_rect_move_pos.sv
// rtl/draw_rect_move_pos.sv - per-frame rectangle position FSM with edge bounce
module draw_rect_pos
    import vga_pkg::*;
#(
    parameter int RECT_W    = W_OF_REC,
    parameter int RECT_H    = H_OF_REC,
    parameter int X_INIT    = X_OF_REC,
    parameter int Y_INIT    = Y_OF_REC,
    parameter int STEP_X    = RECT_STEP_X,
    parameter int STEP_Y    = RECT_STEP_Y,
    parameter int FRAME_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic frame_evt,
    output pix_t rect_x,
    output pix_t rect_y
);

    localparam int          CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [11:0] LIMIT_X  = 12'(HOR_PIXELS - RECT_W);
    localparam logic [11:0] LIMIT_Y  = 12'(VER_PIXELS - RECT_H);
    localparam logic [11:0] STEP_X12 = 12'(STEP_X);
    localparam logic [11:0] STEP_Y12 = 12'(STEP_Y);

    rect_state_t      state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    pix_t             x_q, x_d, y_q, y_d;
    dir_t             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    axis_t            next_x, next_y;

    assign next_x = bounce(x_q, dir_x_q, STEP_X12, LIMIT_X);
    assign next_y = bounce(y_q, dir_y_q, STEP_Y12, LIMIT_Y);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        case (state_q)
            WAIT_VBLNK: begin
                if (frame_evt) state_d = COUNT;
            end
            COUNT: begin
                if (frame_cnt_q == CNT_LAST) begin
                    frame_cnt_d = '0;
                    state_d     = UPDATE;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = WAIT_VBLNK;
                end
            end
            UPDATE: begin
                if (en) begin
                    x_d     = next_x.pos;
                    dir_x_d = next_x.dir;
                    y_d     = next_y.pos;
                    dir_y_d = next_y.dir;
                end
                state_d = WAIT_VBLNK;
            end
            default: state_d = WAIT_VBLNK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_VBLNK;
            frame_cnt_q <= '0;
            x_q         <= pix_t'(X_INIT);
            y_q         <= pix_t'(Y_INIT);
            dir_x_q     <= DIR_FWD;
            dir_y_q     <= DIR_FWD;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
        end
    end

    assign rect_x = x_q;
    assign rect_y = y_q;

endmodule

// File: rtl/draw_rect_move.sv
// rtl/draw_rect_move.sv - one-cycle timing pass-through with a bouncing solid rectangle
module draw_rect_move
    import vga_pkg::*;
#(
    parameter int          RECT_W     = W_OF_REC,
    parameter int          RECT_H     = H_OF_REC,
    parameter logic [11:0] RECT_COLOR = C_OF_REC,
    parameter int          X_INIT     = X_OF_REC,
    parameter int          Y_INIT     = Y_OF_REC,
    parameter int          STEP_X     = RECT_STEP_X,
    parameter int          STEP_Y     = RECT_STEP_Y,
    parameter int          FRAME_DIV  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  pix_t vcount_in,
    input  pix_t hcount_in,
    input  logic vsync_in,
    input  logic hsync_in,
    input  logic vblnk_in,
    input  logic hblnk_in,
    input  rgb_t rgb_in,
    output pix_t vcount_out,
    output pix_t hcount_out,
    output logic vsync_out,
    output logic hsync_out,
    output logic vblnk_out,
    output logic hblnk_out,
    output rgb_t rgb_out,
    output pix_t rect_x,
    output pix_t rect_y
);

    if (RECT_W < 1 || RECT_W > HOR_PIXELS) begin : g_chk_w
        $error("RECT_W must be 1..HOR_PIXELS");
    end
    if (RECT_H < 1 || RECT_H > VER_PIXELS) begin : g_chk_h
        $error("RECT_H must be 1..VER_PIXELS");
    end
    if (STEP_X < 1 || STEP_Y < 1) begin : g_chk_step
        $error("STEP_X and STEP_Y must be at least 1");
    end
    if (FRAME_DIV < 1) begin : g_chk_div
        $error("FRAME_DIV must be at least 1");
    end

    localparam logic [11:0] W_M1 = 12'(RECT_W - 1);
    localparam logic [11:0] H_M1 = 12'(RECT_H - 1);

    tbus_t       out_q, out_d;
    logic        vblnk_prev_q, vblnk_prev_d;
    logic        armed_q, armed_d;
    logic        frame_evt;
    logic        hit;
    logic [11:0] h12, v12, x12, y12;

    assign h12 = {1'b0, hcount_in};
    assign v12 = {1'b0, vcount_in};
    assign x12 = {1'b0, rect_x};
    assign y12 = {1'b0, rect_y};

    // armed stays low until vblnk has been seen low once, so a vblank that is
    // already in progress when reset releases does not count as a new frame
    always_comb begin
        vblnk_prev_d = vblnk_in;
        armed_d      = armed_q | ~vblnk_in;
        frame_evt    = vblnk_in & ~vblnk_prev_q & armed_q;

        hit = (h12 >= x12) && (h12 <= x12 + W_M1) &&
              (v12 >= y12) && (v12 <= y12 + H_M1) &&
              !hblnk_in && !vblnk_in;

        out_d.vcount = vcount_in;
        out_d.hcount = hcount_in;
        out_d.vsync  = vsync_in;
        out_d.hsync  = hsync_in;
        out_d.vblnk  = vblnk_in;
        out_d.hblnk  = hblnk_in;
        out_d.rgb    = hit ? RECT_COLOR : rgb_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            vblnk_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            out_q        <= out_d;
            vblnk_prev_q <= vblnk_prev_d;
            armed_q      <= armed_d;
        end
    end

    draw_rect_pos #(
        .RECT_W    (RECT_W),
        .RECT_H    (RECT_H),
        .X_INIT    (X_INIT),
        .Y_INIT    (Y_INIT),
        .STEP_X    (STEP_X),
        .STEP_Y    (STEP_Y),
        .FRAME_DIV (FRAME_DIV)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .frame_evt (frame_evt),
        .rect_x    (rect_x),
        .rect_y    (rect_y)
    );

    assign vcount_out = out_q.vcount;
    assign hcount_out = out_q.hcount;
    assign vsync_out  = out_q.vsync;
    assign hsync_out  = out_q.hsync;
    assign vblnk_out  = out_q.vblnk;
    assign hblnk_out  = out_q.hblnk;
    assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_rect_move.sv
// tb/tb_draw_rect_move.sv - directed self-checking bench for draw_rect_move
module tb_draw_rect_move;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    always #12 clk = ~clk;

    draw_rect_move_if bus_in ();
    draw_rect_move_if bus_out ();
    draw_rect_move_if bus_out3 ();

    pix_t rx, ry, rx3, ry3;
    int   n_tests = 0;
    int   n_fail  = 0;

    draw_rect_move dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .vcount_in  (bus_in.vcount),
        .hcount_in  (bus_in.hcount),
        .vsync_in   (bus_in.vsync),
        .hsync_in   (bus_in.hsync),
        .vblnk_in   (bus_in.vblnk),
        .hblnk_in   (bus_in.hblnk),
        .rgb_in     (bus_in.rgb),
        .vcount_out (bus_out.vcount),
        .hcount_out (bus_out.hcount),
        .vsync_out  (bus_out.vsync),
        .hsync_out  (bus_out.hsync),
        .vblnk_out  (bus_out.vblnk),
        .hblnk_out  (bus_out.hblnk),
        .rgb_out    (bus_out.rgb),
        .rect_x     (rx),
        .rect_y     (ry)
    );

    draw_rect_move #(.FRAME_DIV(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .vcount_in  (bus_in.vcount),
        .hcount_in  (bus_in.hcount),
        .vsync_in   (bus_in.vsync),
        .hsync_in   (bus_in.hsync),
        .vblnk_in   (bus_in.vblnk),
        .hblnk_in   (bus_in.hblnk),
        .rgb_in     (bus_in.rgb),
        .vcount_out (bus_out3.vcount),
        .hcount_out (bus_out3.hcount),
        .vsync_out  (bus_out3.vsync),
        .hsync_out  (bus_out3.hsync),
        .vblnk_out  (bus_out3.vblnk),
        .hblnk_out  (bus_out3.hblnk),
        .rgb_out    (bus_out3.rgb),
        .rect_x     (rx3),
        .rect_y     (ry3)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int h, input int v, input logic hb, input logic vb,
                           input logic [11:0] c);
        bus_in.hcount = pix_t'(h);
        bus_in.vcount = pix_t'(v);
        bus_in.hblnk  = hb;
        bus_in.vblnk  = vb;
        bus_in.hsync  = 1'b0;
        bus_in.vsync  = 1'b0;
        bus_in.rgb    = c;
    endtask

    task automatic run_frame();
        bus_in.vblnk = 1'b0;
        repeat (2) step();
        bus_in.vblnk = 1'b1;
        repeat (4) step();
    endtask

    task automatic do_reset(input logic vb);
        rst_n = 1'b0;
        bus_in.vblnk = vb;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] timing_out();
        return 32'({bus_out.vcount, bus_out.hcount, bus_out.vsync, bus_out.hsync,
                    bus_out.vblnk, bus_out.hblnk});
    endfunction

    int          ph [4] = '{100, 99, 499, 500};
    int          pv [4] = '{200, 200, 499, 499};
    logic [11:0] pc [4] = '{12'hAF0, 12'h000, 12'hAF0, 12'h000};

    initial begin
        en = 1'b0;
        rst_n = 1'b0;
        set_pix(0, 0, 1'b0, 1'b0, 12'h000);

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bus_in.hcount = pix_t'($urandom);
            bus_in.vcount = pix_t'($urandom);
            bus_in.hsync  = 1'($urandom);
            bus_in.vsync  = 1'($urandom);
            bus_in.hblnk  = 1'($urandom);
            bus_in.vblnk  = 1'($urandom);
            bus_in.rgb    = rgb_t'($urandom);
            step();
        end
        check("rst_timing", timing_out(), 32'd0);
        check("rst_rgb", 32'(bus_out.rgb), 32'd0);
        check("rst_x", 32'(rx), 32'd100);
        check("rst_y", 32'(ry), 32'd200);
        rst_n = 1'b1;

        // static draw around the rectangle corners
        for (int i = 0; i < 4; i++) begin
            set_pix(ph[i], pv[i], 1'b0, 1'b0, 12'h000);
            step();
            check($sformatf("pix_%0d_%0d", ph[i], pv[i]), 32'(bus_out.rgb), 32'(pc[i]));
        end

        // blank masking and pass-through
        set_pix(150, 250, 1'b1, 1'b0, 12'h123);
        bus_in.hsync = 1'b1;
        bus_in.vsync = 1'b1;
        step();
        check("hblnk_mask", 32'(bus_out.rgb), 32'h123);
        check("timing_pass", timing_out(), 32'({11'd250, 11'd150, 1'b1, 1'b1, 1'b0, 1'b1}));
        set_pix(150, 250, 1'b0, 1'b0, 12'h456);
        step();
        check("inside_hit", 32'(bus_out.rgb), 32'hAF0);
        set_pix(150, 250, 1'b0, 1'b1, 12'h456);
        step();
        check("vblnk_mask", 32'(bus_out.rgb), 32'h456);

        // motion and frame divider
        en = 1'b1;
        set_pix(0, 0, 1'b0, 1'b0, 12'h000);
        do_reset(1'b0);
        run_frame();
        check("f1_x", 32'(rx), 32'd102);
        check("f1_y", 32'(ry), 32'd201);
        check("div3_f1_x", 32'(rx3), 32'd100);
        run_frame();
        check("div3_f2_x", 32'(rx3), 32'd100);
        check("div3_f2_y", 32'(ry3), 32'd200);
        run_frame();
        check("div3_f3_x", 32'(rx3), 32'd102);
        check("div3_f3_y", 32'(ry3), 32'd201);

        // bounce on both axes
        for (int f = 4; f <= 100; f++) run_frame();
        check("f100_x", 32'(rx), 32'd300);
        check("f100_y", 32'(ry), 32'd300);
        check("f100_dir_y", 32'(dut.u_pos.dir_y_q), 32'(DIR_REV));
        run_frame();
        check("f101_y", 32'(ry), 32'd299);
        for (int f = 102; f <= 150; f++) run_frame();
        check("f150_x", 32'(rx), 32'd400);
        check("f150_dir_x", 32'(dut.u_pos.dir_x_q), 32'(DIR_REV));
        check("f150_y", 32'(ry), 32'd250);
        run_frame();
        check("f151_x", 32'(rx), 32'd398);

        // reset during UPDATE
        do_reset(1'b0);
        for (int f = 1; f <= 10; f++) run_frame();
        check("f10_x", 32'(rx), 32'd120);
        check("f10_y", 32'(ry), 32'd210);
        bus_in.vblnk = 1'b0;
        repeat (2) step();
        bus_in.vblnk = 1'b1;
        repeat (2) step();
        check("in_update", 32'(dut.u_pos.state_q), 32'(UPDATE));
        check("hold_until_update_end", 32'(rx), 32'd120);
        rst_n = 1'b0;
        step();
        check("midrst_x", 32'(rx), 32'd100);
        check("midrst_y", 32'(ry), 32'd200);
        check("midrst_timing", timing_out(), 32'd0);
        check("midrst_rgb", 32'(bus_out.rgb), 32'd0);
        check("midrst_dirs", 32'({dut.u_pos.dir_x_q, dut.u_pos.dir_y_q}), 32'd0);

        // vblnk already high at reset release gives no event
        rst_n = 1'b1;
        repeat (5) step();
        check("no_evt_x", 32'(rx), 32'd100);
        run_frame();
        check("after_rel_x", 32'(rx), 32'd102);
        check("after_rel_y", 32'(ry), 32'd201);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
